// File: rtl/tx_ltssm_os_gen.sv
// ---------------------------------------------------------------------------
// tx_ltssm_os_gen
//
// Generates the training ordered sets (TS1 / TS2 / idle data) that the
// transmit side of the LTSSM sends in each substate. It counts the sets the
// downstream side accepts and raises finish once the substate's target count
// has been reached.
//
// Ports
//   clk                    rising-edge clock
//   reset                  synchronous, active-high reset
//   substate[3:0]          LTSSM substate code (0..9 defined, 10..15 silent)
//   linkNumber[7:0]        link number for the configuration substates
//   numberOfDetectedLanes  active lane count, clamped to 16
//   rateid[7:0]            data-rate identifier placed in byte 4
//   osReady                downstream accepts the current sets
//   orderedSets[2047:0]    16 lanes x 128 bits, lane k at [128k+127:128k]
//   validOrderedSets       orderedSets is valid
//   txElectricalIdle       transmitter held in electrical idle
//   finish                 required count for this substate reached (level)
// ---------------------------------------------------------------------------
module tx_ltssm_os_gen #(
    parameter int POLL_ACTIVE_COUNT = 1024,
    parameter int MIN_COUNT         = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    substate,
    input  logic [7:0]    linkNumber,
    input  logic [4:0]    numberOfDetectedLanes,
    input  logic [7:0]    rateid,
    input  logic          osReady,
    output logic [2047:0] orderedSets,
    output logic          validOrderedSets,
    output logic          txElectricalIdle,
    output logic          finish
);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        HOLD
    } state_t;

    localparam logic [7:0]  COM_BYTE    = 8'hF7;
    localparam logic [7:0]  PAD_BYTE    = 8'hF7;
    localparam logic [7:0]  NFTS_BYTE   = 8'hAA;
    localparam logic [7:0]  TS1_ID      = 8'h2A;
    localparam logic [7:0]  TS2_ID      = 8'h25;
    localparam logic [10:0] POLL_TARGET = 11'(POLL_ACTIVE_COUNT);
    localparam logic [10:0] MIN_TARGET  = 11'(MIN_COUNT);

    state_t        state;
    state_t        state_next;
    logic [3:0]    latched_substate;
    logic [10:0]   count;
    logic [10:0]   count_next;
    logic [2047:0] sets_next;
    logic          finish_next;

    logic          entry;
    logic          handshake;
    logic          transmit;
    logic [10:0]   target;
    logic [7:0]    ident;
    logic          link_pad;
    logic          lane_pad;
    logic [4:0]    lane_limit;

    // Any difference from the latched substate is an entry; the latched value
    // resets to 4'hF so the first substate seen after reset counts as one.
    assign entry     = (substate != latched_substate);
    assign handshake = validOrderedSets && osReady;

    // Substate decode: which set to send, which fields are padded, and how
    // many accepted sets the substate needs.
    always_comb begin
        transmit   = (substate >= 4'd2) && (substate <= 4'd9);
        target     = (substate == 4'd2) ? POLL_TARGET : MIN_TARGET;
        ident      = ((substate == 4'd3) || (substate == 4'd8)) ? TS2_ID : TS1_ID;
        link_pad   = (substate <= 4'd3);
        lane_pad   = (substate <= 4'd4);
        lane_limit = (numberOfDetectedLanes > 5'd16) ? 5'd16 : numberOfDetectedLanes;
    end

    // Next-state and count logic. An entry always restarts from zero, which
    // also throws away a handshake landing in the same cycle as the change.
    always_comb begin
        state_next  = state;
        count_next  = count;
        finish_next = 1'b0;
        if (!transmit) begin
            state_next = IDLE;
            count_next = '0;
        end else if (entry) begin
            state_next = SEND;
            count_next = '0;
        end else begin
            case (state)
                IDLE: state_next = SEND;
                SEND: begin
                    if (handshake) begin
                        count_next = count + 11'd1;
                    end
                    if (count_next >= target) begin
                        state_next = HOLD;
                    end
                end
                HOLD:    state_next = HOLD;
                default: state_next = IDLE;
            endcase
        end
        if (substate <= 4'd1) begin
            finish_next = 1'b1;
        end else if (transmit) begin
            finish_next = (state_next == HOLD);
        end
    end

    // Set assembly. A stalled valid set is held unchanged until accepted,
    // unless the substate moves on. Lanes beyond the detected count stay 0,
    // and configurationIdle sends all-zero data.
    always_comb begin
        sets_next = '0;
        if (validOrderedSets && !osReady && !entry) begin
            sets_next = orderedSets;
        end else if (transmit && (substate != 4'd9)) begin
            for (int k = 0; k < 16; k++) begin
                if (5'(k) < lane_limit) begin
                    sets_next[128*k +: 128] = {{11{ident}}, rateid, NFTS_BYTE,
                                               lane_pad ? PAD_BYTE : 8'(k),
                                               link_pad ? PAD_BYTE : linkNumber,
                                               COM_BYTE};
                end
            end
        end
    end

    // State, count and all outputs are registered together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            count            <= '0;
            latched_substate <= 4'hF;
            orderedSets      <= '0;
            validOrderedSets <= 1'b0;
            txElectricalIdle <= 1'b1;
            finish           <= 1'b0;
        end else begin
            state            <= state_next;
            count            <= count_next;
            latched_substate <= substate;
            orderedSets      <= sets_next;
            validOrderedSets <= transmit;
            txElectricalIdle <= !transmit;
            finish           <= finish_next;
        end
    end

endmodule

// File: tb/tb_tx_ltssm_os_gen.sv
// ---------------------------------------------------------------------------
// tb_tx_ltssm_os_gen
//
// Table-driven check of the set contents on substate entry, followed by
// hand-written sequences for counting, stalls, substate changes, reset and
// the hold behaviour after finish.
// ---------------------------------------------------------------------------
module tb_tx_ltssm_os_gen;

    localparam logic [87:0] I1 = 88'h2A2A2A2A2A2A2A2A2A2A2A;
    localparam logic [87:0] I2 = 88'h2525252525252525252525;
    localparam logic [127:0] TS1_PAD = {I1, 8'hAA, 8'hAA, 8'hF7, 8'hF7, 8'hF7};
    localparam logic [127:0] TS2_PAD = {I2, 8'hAA, 8'hAA, 8'hF7, 8'hF7, 8'hF7};

    logic          clk;
    logic          reset;
    logic [3:0]    substate;
    logic [7:0]    linkNumber;
    logic [4:0]    numberOfDetectedLanes;
    logic [7:0]    rateid;
    logic          osReady;
    logic [2047:0] orderedSets;
    logic          validOrderedSets;
    logic          txElectricalIdle;
    logic          finish;

    int num_compared   = 0;
    int num_mismatched = 0;

    typedef struct {
        logic [3:0]   sub;
        logic [7:0]   link;
        logic [4:0]   lanes;
        logic [7:0]   rate;
        logic [127:0] lane0;
        logic [127:0] lane1;
        logic [127:0] lane15;
        logic         valid;
        logic         eidle;
        logic         fin;
    } vec_t;

    vec_t vecs[13];

    tx_ltssm_os_gen #(
        .POLL_ACTIVE_COUNT(8),
        .MIN_COUNT(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .substate(substate),
        .linkNumber(linkNumber),
        .numberOfDetectedLanes(numberOfDetectedLanes),
        .rateid(rateid),
        .osReady(osReady),
        .orderedSets(orderedSets),
        .validOrderedSets(validOrderedSets),
        .txElectricalIdle(txElectricalIdle),
        .finish(finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [3:0] sub, input logic [7:0] link,
                                 input logic [4:0] lanes, input logic [7:0] rate,
                                 input logic ready);
        substate              = sub;
        linkNumber            = link;
        numberOfDetectedLanes = lanes;
        rateid                = rate;
        osReady               = ready;
    endtask

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        num_compared++;
        if (actual !== expected) begin
            num_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkReset(input string tag);
        checkOutput({tag, ".lane0"}, orderedSets[127:0], '0);
        checkOutput({tag, ".lane15"}, orderedSets[2047:1920], '0);
        checkOutput({tag, ".valid"}, 128'(validOrderedSets), 128'd0);
        checkOutput({tag, ".eidle"}, 128'(txElectricalIdle), 128'd1);
        checkOutput({tag, ".finish"}, 128'(finish), 128'd0);
    endtask

    // Streams sets for a while after an entry, tracking accepted sets and
    // the expected finish level; optionally toggles osReady to create stalls.
    task automatic runHandshakes(input string tag, input int target, input bit toggle,
                                 input logic [127:0] exp_lane0);
        int            hs;
        bit            prev_stall;
        logic [2047:0] prev;
        hs         = 0;
        prev_stall = 1'b0;
        prev       = '0;
        for (int i = 0; i < 2 * target + 6; i++) begin
            checkOutput({tag, ".finish"}, 128'(finish), 128'(hs >= target));
            checkOutput({tag, ".valid"}, 128'(validOrderedSets), 128'd1);
            checkOutput({tag, ".lane0"}, orderedSets[127:0], exp_lane0);
            if (prev_stall) begin
                num_compared++;
                if (orderedSets !== prev) begin
                    num_mismatched++;
                    $display("[TB] FAIL %s.stall_hold: got low %h, expected low %h",
                             tag, orderedSets[255:0], prev[255:0]);
                end
            end
            osReady    = toggle ? ~osReady : 1'b1;
            if (osReady) hs++;
            prev_stall = !osReady;
            prev       = orderedSets;
            step();
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{4'd2,  8'hBB, 5'd2,  8'hAA, TS1_PAD, TS1_PAD, '0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{4'd3,  8'hBB, 5'd2,  8'hAA, TS2_PAD, TS2_PAD, '0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{4'd4,  8'hBB, 5'd2,  8'hAA, {I1, 8'hAA, 8'hAA, 8'hF7, 8'hBB, 8'hF7},
                     {I1, 8'hAA, 8'hAA, 8'hF7, 8'hBB, 8'hF7}, '0, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{4'd5,  8'hBB, 5'd2,  8'hAA, {I1, 8'hAA, 8'hAA, 8'h00, 8'hBB, 8'hF7},
                     {I1, 8'hAA, 8'hAA, 8'h01, 8'hBB, 8'hF7}, '0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{4'd6,  8'hBB, 5'd2,  8'hAA, {I1, 8'hAA, 8'hAA, 8'h00, 8'hBB, 8'hF7},
                     {I1, 8'hAA, 8'hAA, 8'h01, 8'hBB, 8'hF7}, '0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{4'd7,  8'hBB, 5'd2,  8'hAA, {I1, 8'hAA, 8'hAA, 8'h00, 8'hBB, 8'hF7},
                     {I1, 8'hAA, 8'hAA, 8'h01, 8'hBB, 8'hF7}, '0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{4'd8,  8'hBB, 5'd2,  8'hAA, {I2, 8'hAA, 8'hAA, 8'h00, 8'hBB, 8'hF7},
                     {I2, 8'hAA, 8'hAA, 8'h01, 8'hBB, 8'hF7}, '0, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{4'd9,  8'hBB, 5'd2,  8'hAA, '0, '0, '0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{4'd0,  8'hBB, 5'd2,  8'hAA, '0, '0, '0, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{4'd1,  8'hBB, 5'd2,  8'hAA, '0, '0, '0, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{4'd12, 8'hBB, 5'd2,  8'hAA, '0, '0, '0, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{4'd5,  8'hBB, 5'd20, 8'h55, {I1, 8'h55, 8'hAA, 8'h00, 8'hBB, 8'hF7},
                     {I1, 8'h55, 8'hAA, 8'h01, 8'hBB, 8'hF7},
                     {I1, 8'h55, 8'hAA, 8'h0F, 8'hBB, 8'hF7}, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{4'd6,  8'hBB, 5'd1,  8'hAA, {I1, 8'hAA, 8'hAA, 8'h00, 8'hBB, 8'hF7},
                     '0, '0, 1'b1, 1'b0, 1'b0};

        reset = 1'b1;
        applyStimulus(4'hF, 8'hBB, 5'd2, 8'hAA, 1'b0);
        step();
        step();
        checkReset("reset");
        reset = 1'b0;
        step();
        checkReset("idle15");

        // Entry contents for each substate, with osReady low so nothing counts.
        for (int v = 0; v < 13; v++) begin
            applyStimulus(vecs[v].sub, vecs[v].link, vecs[v].lanes, vecs[v].rate, 1'b0);
            step();
            checkOutput($sformatf("vec%0d.lane0", v), orderedSets[127:0], vecs[v].lane0);
            checkOutput($sformatf("vec%0d.lane1", v), orderedSets[255:128], vecs[v].lane1);
            checkOutput($sformatf("vec%0d.lane15", v), orderedSets[2047:1920], vecs[v].lane15);
            checkOutput($sformatf("vec%0d.valid", v), 128'(validOrderedSets), 128'(vecs[v].valid));
            checkOutput($sformatf("vec%0d.eidle", v), 128'(txElectricalIdle), 128'(vecs[v].eidle));
            checkOutput($sformatf("vec%0d.finish", v), 128'(finish), 128'(vecs[v].fin));
        end

        // pollingActive with a reduced target of 8.
        applyStimulus(4'd2, 8'hBB, 5'd2, 8'hAA, 1'b1);
        step();
        runHandshakes("poll", 8, 1'b0, TS1_PAD);

        // pollingActive -> pollingConfiguration after 5 handshakes, the
        // change coinciding with a sixth; then stalled TS2 counting.
        applyStimulus(4'd0, 8'hBB, 5'd2, 8'hAA, 1'b1);
        step();
        applyStimulus(4'd2, 8'hBB, 5'd2, 8'hAA, 1'b1);
        step();
        repeat (5) step();
        applyStimulus(4'd3, 8'hBB, 5'd2, 8'hAA, 1'b1);
        step();
        runHandshakes("ts2", 16, 1'b1, TS2_PAD);

        // configurationLanenumWait streams on in HOLD after finish.
        applyStimulus(4'd6, 8'hBB, 5'd2, 8'hAA, 1'b1);
        step();
        runHandshakes("cfg6", 16, 1'b0, {I1, 8'hAA, 8'hAA, 8'h00, 8'hBB, 8'hF7});
        checkOutput("cfg6.lane1", orderedSets[255:128], {I1, 8'hAA, 8'hAA, 8'h01, 8'hBB, 8'hF7});

        // linkNumber change mid-count keeps the count running.
        applyStimulus(4'd4, 8'hBB, 5'd2, 8'hAA, 1'b1);
        step();
        repeat (10) step();
        linkNumber = 8'hCC;
        step();
        checkOutput("link.lane0", orderedSets[127:0], {I1, 8'hAA, 8'hAA, 8'hF7, 8'hCC, 8'hF7});
        checkOutput("link.finish11", 128'(finish), 128'd0);
        repeat (4) step();
        checkOutput("link.finish15", 128'(finish), 128'd0);
        step();
        checkOutput("link.finish16", 128'(finish), 128'd1);

        // Reset pulse during configurationComplete, substate held at 8.
        applyStimulus(4'd8, 8'hBB, 5'd2, 8'hAA, 1'b1);
        step();
        repeat (3) step();
        reset = 1'b1;
        step();
        checkReset("midreset");
        reset = 1'b0;
        step();
        runHandshakes("cfg8", 16, 1'b0, {I2, 8'hAA, 8'hAA, 8'h00, 8'hBB, 8'hF7});

        // configurationIdle: zero data, still valid and counted.
        applyStimulus(4'd9, 8'hBB, 5'd2, 8'hAA, 1'b1);
        step();
        checkOutput("idle9.lane1", orderedSets[255:128], '0);
        runHandshakes("idle9", 16, 1'b0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
